// File: rtl/video_frame_capture.sv
// Single-shot video frame grabber: packs active pixels to RGB332 and writes them at offset + pixel index.
// Define CAPTURE_DECIMATE_EN to capture at 2:1 in both axes (even pixels of even lines only).
module video_frame_capture #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int ADDR_W         = 24,
  parameter int VS_ACTIVE_HIGH = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic [17:0]       offset,
  input  logic              vid_de,
  input  logic              vid_hs,
  input  logic              vid_vs,
  input  logic [23:0]       vid_d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_overrun,
  output logic              err_short
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] H_LIM  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_LIM  = YW'(V_ACTIVE);
  localparam logic          VS_POL = (VS_ACTIVE_HIGH != 0);
`ifdef CAPTURE_DECIMATE_EN
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE / 2);
`else
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FRAME = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              vs_d_q, de_d_q;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_overrun_q, err_overrun_d;
  logic              err_short_q, err_short_d;

  // Sync is only observed externally; nothing in the capture path depends on it.
  logic unused_hs;
  assign unused_hs = vid_hs;

  function automatic logic [7:0] rgb332(input logic [23:0] d);
    return {d[23:21], d[15:13], d[7:6]};
  endfunction

  logic          vs_now, vs_prev, vs_edge, de_fall;
  logic          pix_ok, pix_over, line_end, last_line, keep_pix;
  logic [XW-1:0] x_inc;
  logic [YW-1:0] y_inc;
  logic [ADDR_W-1:0] pix_addr;

  assign vs_now    = (vid_vs == VS_POL);
  assign vs_prev   = (vs_d_q == VS_POL);
  assign vs_edge   = vs_now & ~vs_prev;
  assign de_fall   = de_d_q & ~vid_de;
  assign x_inc     = x_q + XW'(1);
  assign y_inc     = y_q + YW'(1);
  assign pix_ok    = vid_de && (x_q < H_LIM) && (y_q < V_LIM);
  assign pix_over  = vid_de && (x_q == H_LIM);
  assign line_end  = de_fall && (x_q != '0);
  assign last_line = (y_inc == V_LIM);

`ifdef CAPTURE_DECIMATE_EN
  assign keep_pix = ~x_q[0] & ~y_q[0];
  assign pix_addr = line_base_q + ADDR_W'(x_q >> 1);
`else
  assign keep_pix = 1'b1;
  assign pix_addr = line_base_q + ADDR_W'(x_q);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm) state_d = S_ARMED;
      S_ARMED: if (vs_edge) state_d = S_FRAME;
      S_FRAME: begin
        if (vs_edge && (y_q < V_LIM))   state_d = S_DONE;
        else if (line_end && last_line) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base_d        = base_q;
    line_base_d   = line_base_q;
    x_d           = x_q;
    y_d           = y_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    busy_d        = busy_q;
    done_d        = done_q;
    err_overrun_d = err_overrun_q;
    err_short_d   = err_short_q;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          base_d        = ADDR_W'(offset);
          busy_d        = 1'b1;
          done_d        = 1'b0;
          err_overrun_d = 1'b0;
          err_short_d   = 1'b0;
        end
      end
      S_ARMED: begin
        if (vs_edge) begin
          x_d         = '0;
          y_d         = '0;
          line_base_d = base_q;
        end
      end
      S_FRAME: begin
        // A fresh VS ends the frame even mid-line; what was written stays.
        if (vs_edge && (y_q < V_LIM)) begin
          err_short_d = 1'b1;
        end else if (pix_ok) begin
          x_d = x_inc;
          if (keep_pix) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pix_addr;
            wr_data_d = rgb332(vid_d);
          end
        end else if (pix_over) begin
          err_overrun_d = 1'b1;
        end else if (line_end) begin
          x_d = '0;
          y_d = y_inc;
`ifdef CAPTURE_DECIMATE_EN
          if (!y_q[0]) line_base_d = line_base_q + LINE_STEP;
`else
          line_base_d = line_base_q + LINE_STEP;
`endif
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vs_d_q        <= 1'b0;
      de_d_q        <= 1'b0;
      base_q        <= '0;
      line_base_q   <= '0;
      x_q           <= '0;
      y_q           <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_overrun_q <= 1'b0;
      err_short_q   <= 1'b0;
    end else begin
      vs_d_q        <= vid_vs;
      de_d_q        <= vid_de;
      base_q        <= base_d;
      line_base_q   <= line_base_d;
      x_q           <= x_d;
      y_q           <= y_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_overrun_q <= err_overrun_d;
      err_short_q   <= err_short_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_overrun = err_overrun_q;
  assign err_short   = err_short_q;

endmodule

// File: tb/tb_video_frame_capture.sv
// Directed bench for video_frame_capture on a 4x3 frame; expectations follow CAPTURE_DECIMATE_EN if defined.
module tb_video_frame_capture;

  localparam int H = 4;
  localparam int V = 3;
`ifdef CAPTURE_DECIMATE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm = 1'b0;
  logic [17:0] offset = '0;
  logic        vid_de = 1'b0;
  logic        vid_hs = 1'b1;
  logic        vid_vs = 1'b0;
  logic [23:0] vid_d = '0;
  logic        wr_en;
  logic [23:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done, err_overrun, err_short;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_frame_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(24), .VS_ACTIVE_HIGH(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .offset(offset),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_d(vid_d),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_overrun(err_overrun), .err_short(err_short)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one clock cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic a, input logic de, input logic vs, input logic [23:0] d);
    arm = a; vid_de = de; vid_vs = vs; vid_d = d; vid_hs = ~de;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [17:0] off);
    offset = off;
    cyc(1'b1, 1'b0, 1'b0, 24'h0);
    offset = ~off;
    check("busy_on_arm", 32'(busy), 32'd1);
    check("done_clr_on_arm", 32'(done), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic vs_pulse();
    cyc(1'b0, 1'b0, 1'b1, 24'h0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  // Pixel (x,l) carries x in the top red bits and l in the top green bits,
  // so its RGB332 byte is {x[2:0], l[2:0], 2'b00}.
  function automatic logic [23:0] pixel(input int x, input int l);
    logic [23:0] p;
    p = '0;
    p[23:21] = x[2:0];
    p[15:13] = l[2:0];
    return p;
  endfunction

  task automatic do_line(input logic [23:0] base, input int l, input int n,
                         input logic a, input logic white);
    logic        en;
    logic [23:0] ad;
    logic [7:0]  ed;
    for (int x = 0; x < n; x++) begin
      en = (x < H) && (!DEC || ((x % 2) == 0 && (l % 2) == 0));
      ad = DEC ? base + 24'((l / 2) * (H / 2) + x / 2) : base + 24'(l * H + x);
      ed = white ? 8'hFF : {x[2:0], l[2:0], 2'b00};
      cyc(a, 1'b1, 1'b0, white ? 24'hFFFFFF : pixel(x, l));
      check("wr_en", 32'(wr_en), 32'(en));
      if (en) begin
        check("wr_addr", 32'(wr_addr), 32'(ad));
        check("wr_data", 32'(wr_data), 32'(ed));
      end
    end
    cyc(a, 1'b0, 1'b0, 24'h0);
    check("wr_en_gap", 32'(wr_en), 32'd0);
  endtask

  logic [23:0] cpix [4] = '{24'hE040C0, 24'h1F1F3F, 24'hFFFFFF, 24'h000000};
  logic [7:0]  cexp [4] = '{8'hEB, 8'h00, 8'hFF, 8'h00};

  initial begin
    // Reset state
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 24'h0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_overrun", 32'(err_overrun), 32'd0);
    check("rst_err_short", 32'(err_short), 32'd0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 24'h0);

    // Normal white frame; arm held through line 1 must not disturb it
    do_arm(18'h100);
    vs_pulse();
    do_line(24'h100, 0, 4, 1'b0, 1'b1);
    do_line(24'h100, 1, 4, 1'b1, 1'b1);
    do_line(24'h100, 2, 4, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 24'h0);
    check("norm_done", 32'(done), 32'd1);
    check("norm_busy", 32'(busy), 32'd0);
    check("norm_err_overrun", 32'(err_overrun), 32'd0);
    check("norm_err_short", 32'(err_short), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    check("arm_in_done_ignored", 32'(busy), 32'd0);

    // Colour packing
    do_arm(18'h200);
    vs_pulse();
    for (int x = 0; x < 4; x++) begin
      cyc(1'b0, 1'b1, 1'b0, cpix[x]);
      check("col_wr_en", 32'(wr_en), 32'(!DEC || (x % 2) == 0));
      if (!DEC || (x % 2) == 0) begin
        check("col_wr_addr", 32'(wr_addr), DEC ? 32'h200 + 32'(x / 2) : 32'h200 + 32'(x));
        check("col_wr_data", 32'(wr_data), 32'(cexp[x]));
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    do_line(24'h200, 1, 4, 1'b0, 1'b0);
    do_line(24'h200, 2, 4, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    check("col_done", 32'(done), 32'd1);

    // Overrun: 6 DE pixels on line 0
    do_arm(18'h300);
    vs_pulse();
    do_line(24'h300, 0, 6, 1'b0, 1'b0);
    check("ovr_flag", 32'(err_overrun), 32'd1);
    do_line(24'h300, 1, 4, 1'b0, 1'b0);
    do_line(24'h300, 2, 4, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    check("ovr_done", 32'(done), 32'd1);
    check("ovr_flag_sticky", 32'(err_overrun), 32'd1);
    check("ovr_no_short", 32'(err_short), 32'd0);

    // Early VS after two lines
    do_arm(18'h400);
    check("arm_clears_overrun", 32'(err_overrun), 32'd0);
    vs_pulse();
    do_line(24'h400, 0, 4, 1'b0, 1'b0);
    do_line(24'h400, 1, 4, 1'b0, 1'b0);
    check("early_not_done", 32'(done), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 24'h0);
    check("early_err_short", 32'(err_short), 32'd1);
    check("early_wr_en", 32'(wr_en), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    check("early_done", 32'(done), 32'd1);
    check("early_busy", 32'(busy), 32'd0);

    // Top of the 18-bit offset range
    do_arm(18'h3FFFF);
    check("arm_clears_short", 32'(err_short), 32'd0);
    vs_pulse();
    do_line(24'h03FFFF, 0, 4, 1'b0, 1'b0);
    do_line(24'h03FFFF, 1, 4, 1'b0, 1'b0);
    do_line(24'h03FFFF, 2, 4, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    check("wrap_done", 32'(done), 32'd1);

    // Reset mid-line aborts the capture
    do_arm(18'h500);
    vs_pulse();
    cyc(1'b0, 1'b1, 1'b0, pixel(0, 0));
    check("mid_first_wr", 32'(wr_en), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, pixel(1, 0));
    reset_n = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, pixel(2, 0));
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, pixel(3, 0));
    check("post_rst_wr_en", 32'(wr_en), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    vs_pulse();
    cyc(1'b0, 1'b1, 1'b0, pixel(0, 1));
    check("idle_ignores_frame", 32'(wr_en), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
